// File: rtl/uart_bit_serializer_pkg.sv
// Shared constants for the UART bit serializer: default word width,
// FSM state encoding and a width helper used for the per-bit hold counter.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // A one-cycle bit still needs a 1-bit counter so that the declaration stays legal
    function automatic int hold_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_serializer_if.sv
// Word input handshake plus serial output bundle of the serializer.
// master = word source / observer, slave = the serializer itself.
interface uart_bit_serializer_if
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              signal;
    logic              busy;
    logic              word_start;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  signal,
        input  busy,
        input  word_start
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output signal,
        output busy,
        output word_start
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with naturally wrapping pointers and an
// occupancy counter one bit wider than the pointers.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage needs no reset: the counter decides which entries are live
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_sync_fifo_chk.sv
// Simulation-only invariants for the serializer's word FIFO.
// Bound inside the serializer so they follow every instance.
module uart_sync_fifo_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          push,
    input logic          pop,
    input logic          full,
    input logic          empty,
    input logic [CW-1:0] count
);

    // The FSM only pops after it has seen a non-empty FIFO
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));

    a_count_range: assert property (@(posedge clk) disable iff (!reset) (count <= CW'(DEPTH)));

endmodule

// File: rtl/uart_bit_serializer.sv
// Parallel-to-serial feeder: buffers words and shifts them out MSB-first,
// back-to-back while words are queued, idling at 0 otherwise.
module uart_bit_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int BIT_CYCLES = 1
) (
    input logic                  clk,
    input logic                  reset,
    uart_bit_serializer_if.slave bus
);

    localparam int BW = $clog2(DATA_W);
    localparam int HW = hold_width(BIT_CYCLES);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);

    logic [0:0]        state_r;
    logic [0:0]        state_s;
    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] shreg_s;
    logic [BW-1:0]     bit_idx_r;
    logic [BW-1:0]     bit_idx_s;
    logic [HW-1:0]     hold_cnt_r;
    logic [HW-1:0]     hold_cnt_s;
    logic              signal_r;
    logic              signal_s;
    logic              busy_r;
    logic              busy_s;
    logic              word_start_r;
    logic              word_start_s;
    logic              ready_en_r;
    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              load_s;
    logic              full_s;
    logic              empty_s;
    logic [DATA_W-1:0] head_s;
    logic [CW-1:0]     count_s;

    // Ready depends only on registered FIFO state, never on this cycle's pop
    assign in_ready_s     = ready_en_r & ~full_s;
    assign push_s         = bus.in_valid & in_ready_s;
    assign bus.in_ready   = in_ready_s;
    assign bus.signal     = signal_r;
    assign bus.busy       = busy_r;
    assign bus.word_start = word_start_r;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (bus.in_data),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    uart_sync_fifo_chk #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Next-state logic: hold each bit, advance on hold wrap, chain words with no gap
    always_comb begin
        state_s      = state_r;
        shreg_s      = shreg_r;
        bit_idx_s    = bit_idx_r;
        hold_cnt_s   = hold_cnt_r;
        signal_s     = signal_r;
        busy_s       = busy_r;
        word_start_s = 1'b0;
        load_s       = 1'b0;
        pop_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    load_s = 1'b1;
                end else begin
                    signal_s = 1'b0;
                    busy_s   = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (hold_cnt_r != HOLD_LAST) begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end else begin
                    hold_cnt_s = {HW{1'b0}};
                    if (bit_idx_r != BIT_LAST) begin
                        shreg_s   = {shreg_r[DATA_W-2:0], 1'b0};
                        signal_s  = shreg_r[DATA_W-2];
                        bit_idx_s = bit_idx_r + BW'(1);
                    end else if (!empty_s) begin
                        load_s = 1'b1;
                    end else begin
                        signal_s = 1'b0;
                        busy_s   = 1'b0;
                        state_s  = ST_IDLE;
                    end
                end
            end
            default: begin
                signal_s = 1'b0;
                busy_s   = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase

        if (load_s) begin
            pop_s        = 1'b1;
            shreg_s      = head_s;
            signal_s     = head_s[DATA_W-1];
            busy_s       = 1'b1;
            word_start_s = 1'b1;
            bit_idx_s    = {BW{1'b0}};
            hold_cnt_s   = {HW{1'b0}};
            state_s      = ST_SHIFT;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FSM, shift register and registered outputs; reset drops signal at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {DATA_W{1'b0}};
            bit_idx_r    <= {BW{1'b0}};
            hold_cnt_r   <= {HW{1'b0}};
            signal_r     <= 1'b0;
            busy_r       <= 1'b0;
            word_start_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            bit_idx_r    <= bit_idx_s;
            hold_cnt_r   <= hold_cnt_s;
            signal_r     <= signal_s;
            busy_r       <= busy_s;
            word_start_r <= word_start_s;
        end
    end

    // Keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_bit_serializer.sv
// Randomised scoreboard bench: two serializers (1 and 3 cycles per bit), each
// checked every cycle against a timeline model of the expected serial stream.
module tb_uart_bit_serializer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [DW-1:0] word;
        int            ready;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic          rst_v     [2];
    logic [DW-1:0] drv_data  [2];
    logic          drv_valid [2];
    logic          rdy_v     [2];
    logic          sig_v     [2];
    logic          busy_v    [2];
    logic          ws_v      [2];
    bit            mon_en    [2];
    bit            idle_v    [2];

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", name, g, cyc, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int B = (g == 0) ? 1 : 3;

        uart_bit_serializer_if #(.DATA_W(DW)) ifc ();

        uart_bit_serializer #(
            .DATA_W     (DW),
            .FIFO_DEPTH (DEPTH),
            .BIT_CYCLES (B)
        ) dut (
            .clk   (clk),
            .reset (rst_v[g]),
            .bus   (ifc)
        );

        assign ifc.in_data  = drv_data[g];
        assign ifc.in_valid = drv_valid[g];
        assign rdy_v[g]     = ifc.in_ready;
        assign sig_v[g]     = ifc.signal;
        assign busy_v[g]    = ifc.busy;
        assign ws_v[g]      = ifc.word_start;

        // Model: a word starts at max(push edge + 1, end of previous word),
        // then occupies DW*B cycles; otherwise the line idles at 0.
        exp_t q[$];
        exp_t cur;
        bit   in_word = 1'b0;
        int   k = 0;
        logic e_sig, e_busy, e_ws;

        always @(negedge clk) begin
            if (!rst_v[g]) begin
                q.delete();
                in_word = 1'b0;
            end else if (mon_en[g]) begin
                if (!in_word && q.size() > 0 && q[0].ready <= cyc) begin
                    cur = q.pop_front();
                    in_word = 1'b1;
                    k = 0;
                end
                if (in_word) begin
                    e_sig  = cur.word[DW-1-(k/B)];
                    e_busy = 1'b1;
                    e_ws   = (k == 0);
                    k++;
                    if (k == DW * B) in_word = 1'b0;
                end else begin
                    e_sig  = 1'b0;
                    e_busy = 1'b0;
                    e_ws   = 1'b0;
                end
                check("signal", g, 32'(sig_v[g]), 32'(e_sig));
                check("busy", g, 32'(busy_v[g]), 32'(e_busy));
                check("word_start", g, 32'(ws_v[g]), 32'(e_ws));
                check("in_ready", g, 32'(rdy_v[g]), 32'(q.size() != DEPTH));
                if (drv_valid[g] && rdy_v[g]) begin
                    q.push_back('{word: drv_data[g], ready: cyc + 2});
                end
            end
            idle_v[g] = (q.size() == 0) && !in_word;
        end
    end

    task automatic send(input int g, input logic [DW-1:0] d);
        int t = 0;
        drv_data[g]  = d;
        drv_valid[g] = 1'b1;
        @(negedge clk);
        while (!rdy_v[g] && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!rdy_v[g]) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout dut%0d actual=in_ready_low required=accept", g);
        end
        @(posedge clk);
        #1;
        drv_valid[g] = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(idle_v[0] && idle_v[1]) && t < 1000) begin
            t++;
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (!(idle_v[0] && idle_v[1])) begin
            n_fail++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int g;
        for (int i = 0; i < 2; i++) begin
            rst_v[i]     = 1'b0;
            drv_valid[i] = 1'b0;
            drv_data[i]  = {DW{1'b0}};
            mon_en[i]    = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_signal", i, 32'(sig_v[i]), 32'd0);
            check("rst_busy", i, 32'(busy_v[i]), 32'd0);
            check("rst_word_start", i, 32'(ws_v[i]), 32'd0);
            check("rst_in_ready", i, 32'(rdy_v[i]), 32'd0);
            rst_v[i] = 1'b1;
        end
        #1;
        for (int i = 0; i < 2; i++) check("ready_before_edge", i, 32'(rdy_v[i]), 32'd0);
        @(posedge clk);
        #1;
        mon_en[0] = 1'b1;
        mon_en[1] = 1'b1;

        send(0, 8'h96);
        wait_idle();
        send(0, 8'hAA);
        send(0, 8'h55);
        wait_idle();
        for (int i = 0; i < 6; i++) send(0, 8'(8'h31 + 8'(i * 17)));
        wait_idle();
        send(1, 8'h91);
        wait_idle();

        // Reset in the middle of bit 4 of 0xF0 with two words still queued
        send(0, 8'hF0);
        send(0, 8'hAA);
        send(0, 8'h55);
        repeat (3) @(posedge clk);
        #2;
        mon_en[0] = 1'b0;
        rst_v[0]  = 1'b0;
        #1;
        check("async_rst_signal", 0, 32'(sig_v[0]), 32'd0);
        check("async_rst_busy", 0, 32'(busy_v[0]), 32'd0);
        check("async_rst_word_start", 0, 32'(ws_v[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_v[0] = 1'b1;
        @(posedge clk);
        #1;
        mon_en[0] = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            g = int'($urandom_range(0, 1));
            send(g, 8'($urandom_range(0, 255)));
            n = int'($urandom_range(0, 3));
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        repeat (4) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
